// File: rtl/fp_rf_pkg.sv
// Shared types and specifier helpers for the multi-port FP register file.
// A register specifier is RAW bits wide: the MSB marks the operand as a valid
// FP register, the low RAW-1 bits select the entry. The helpers take the
// specifier zero-extended to SPEC_W bits plus the real width, so one
// definition serves every NREGS configuration.
package fp_rf_pkg;

    localparam int SPEC_W = 6;  // widest specifier (NREGS = 32)
    localparam int IDX_W  = 5;  // widest index

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

    function automatic logic fp_spec_valid(input int raw, input logic [SPEC_W-1:0] spec);
        logic v;
        v = 1'b0;
        for (int b = 0; b < SPEC_W; b++)
            if (b == raw - 1) v = spec[b];
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] fp_spec_idx(input int raw, input logic [SPEC_W-1:0] spec);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int b = 0; b < IDX_W; b++)
            if (b < raw - 1) r[b] = spec[b];
        return r;
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Per-register pending scoreboard for FP issue-stage hazard detection.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset (clears pending)
//   run            block is out of its clear phase; writes/issues honoured
//   rd_addr        NRD packed source specifiers
//   wr_en/wr_addr  NWR writeback enables and specifiers
//   iss_en/iss_addr destination reservation request
//   flush          clear every pending bit, drop same-cycle reservation
//   rd_busy        source pending and not satisfied by a same-cycle writeback
//   iss_stall      reservation refused (clear phase or WAW hazard)
module fp_scoreboard
    import fp_rf_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NRD   = 3,
    parameter int NWR   = 2,
    parameter int RAW   = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic [NRD*RAW-1:0] rd_addr,
    input  logic [NWR-1:0]     wr_en,
    input  logic [NWR*RAW-1:0] wr_addr,
    input  logic               iss_en,
    input  logic [RAW-1:0]     iss_addr,
    input  logic               flush,
    output logic [NRD-1:0]     rd_busy,
    output logic               iss_stall
);

    localparam int IW = RAW - 1;

    logic [NREGS-1:0]          pending;
    logic [NREGS-1:0]          pend_nxt;
    logic [NWR-1:0]            wv;
    logic [NWR-1:0][IW-1:0]    widx;
    logic [NRD-1:0]            rv;
    logic [NRD-1:0][IW-1:0]    ridx;
    logic                      iv;
    logic [IW-1:0]             iidx;
    logic                      ihit;

    always_comb begin
        for (int w = 0; w < NWR; w++) begin
            wv[w]   = run & wr_en[w] & fp_spec_valid(RAW, SPEC_W'(wr_addr[w*RAW +: RAW]));
            widx[w] = IW'(fp_spec_idx(RAW, SPEC_W'(wr_addr[w*RAW +: RAW])));
        end
        for (int i = 0; i < NRD; i++) begin
            rv[i]   = fp_spec_valid(RAW, SPEC_W'(rd_addr[i*RAW +: RAW]));
            ridx[i] = IW'(fp_spec_idx(RAW, SPEC_W'(rd_addr[i*RAW +: RAW])));
        end
        iv   = fp_spec_valid(RAW, SPEC_W'(iss_addr));
        iidx = IW'(fp_spec_idx(RAW, SPEC_W'(iss_addr)));
    end

    // A writeback landing this cycle satisfies the dependency immediately.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            logic hit;
            hit = 1'b0;
            for (int w = 0; w < NWR; w++)
                if (wv[w] && widx[w] == ridx[i]) hit = 1'b1;
            rd_busy[i] = run & rv[i] & pending[ridx[i]] & ~hit;
        end
        ihit = 1'b0;
        for (int w = 0; w < NWR; w++)
            if (wv[w] && widx[w] == iidx) ihit = 1'b1;
        iss_stall = ~run | (iv & pending[iidx] & ~ihit);
    end

    // Priority (lowest to highest): writeback clear, issue set, flush.
    always_comb begin
        pend_nxt = pending;
        for (int w = 0; w < NWR; w++)
            if (wv[w]) pend_nxt[widx[w]] = 1'b0;
        if (iss_en && iv && !iss_stall && !flush) pend_nxt[iidx] = 1'b1;
        if (flush) pend_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) pending <= '0;
        else          pending <= pend_nxt;
    end

endmodule

// File: rtl/fp_regfile_mp.sv
// Multi-port FP register file with write-to-read bypass, pending scoreboard
// and a sequential clear engine. Storage has no reset so it can map to
// LUTRAM; after reset the engine zeroes one entry per cycle.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   rd_addr_pi/rd_data_po   NRD combinational read ports (packed slices)
//   rd_busy_po              per read port pending indication
//   wr_en_pi/wr_addr_pi/wr_data_pi  NWR write ports (highest port wins)
//   iss_en_pi/iss_addr_pi   destination reservation
//   iss_stall_po            reservation refused
//   flush_pi                clear all pending bits
//   init_done_po            clear engine finished
module fp_regfile_mp
    import fp_rf_pkg::*;
#(
    parameter int  XLEN  = 32,
    parameter int  NREGS = 32,
    parameter int  NRD   = 3,
    parameter int  NWR   = 2,
    parameter bit  DEBUG = 1'b0,
    localparam int RAW   = $clog2(NREGS) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*RAW-1:0]  rd_addr_pi,
    output logic [NRD*XLEN-1:0] rd_data_po,
    output logic [NRD-1:0]      rd_busy_po,
    input  logic [NWR-1:0]      wr_en_pi,
    input  logic [NWR*RAW-1:0]  wr_addr_pi,
    input  logic [NWR*XLEN-1:0] wr_data_pi,
    input  logic                iss_en_pi,
    input  logic [RAW-1:0]      iss_addr_pi,
    output logic                iss_stall_po,
    input  logic                flush_pi,
    output logic                init_done_po
);

    localparam int IW = RAW - 1;

    rf_state_t              state;
    logic [IW-1:0]          cnt;
    logic                   init_done;
    logic                   run;
    logic [XLEN-1:0]        mem [NREGS];
    logic [NWR-1:0]         wv;
    logic [NWR-1:0][IW-1:0] widx;

    assign run          = (state == RF_RUN);
    assign init_done_po = init_done;

    always_comb begin
        for (int w = 0; w < NWR; w++) begin
            wv[w]   = run & wr_en_pi[w] & fp_spec_valid(RAW, SPEC_W'(wr_addr_pi[w*RAW +: RAW]));
            widx[w] = IW'(fp_spec_idx(RAW, SPEC_W'(wr_addr_pi[w*RAW +: RAW])));
        end
    end

    // Clear FSM: walks cnt over every entry, then hands over to normal operation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= RF_INIT;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                RF_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == IW'(NREGS - 1)) begin
                        state     <= RF_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= RF_RUN;
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    // Storage. Later ports overwrite earlier ones, so the highest port wins.
    // Held off while reset is asserted so the clear walk starts cleanly.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state == RF_INIT) begin
                mem[cnt] <= '0;
            end else begin
                for (int w = 0; w < NWR; w++)
                    if (wv[w]) mem[widx[w]] <= wr_data_pi[w*XLEN +: XLEN];
            end
        end
    end

    // Combinational reads with same-cycle write bypass (highest port wins).
    always_comb begin
        rd_data_po = '0;
        for (int i = 0; i < NRD; i++) begin
            logic          v;
            logic [IW-1:0] idx;
            logic [XLEN-1:0] d;
            v   = fp_spec_valid(RAW, SPEC_W'(rd_addr_pi[i*RAW +: RAW]));
            idx = IW'(fp_spec_idx(RAW, SPEC_W'(rd_addr_pi[i*RAW +: RAW])));
            d   = mem[idx];
            for (int w = 0; w < NWR; w++)
                if (wv[w] && widx[w] == idx) d = wr_data_pi[w*XLEN +: XLEN];
            rd_data_po[i*XLEN +: XLEN] = (run && v) ? d : '0;
        end
    end

    fp_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .RAW   (RAW)
    ) u_sb (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .rd_addr   (rd_addr_pi),
        .wr_en     (wr_en_pi),
        .wr_addr   (wr_addr_pi),
        .iss_en    (iss_en_pi),
        .iss_addr  (iss_addr_pi),
        .flush     (flush_pi),
        .rd_busy   (rd_busy_po),
        .iss_stall (iss_stall_po)
    );

`ifndef SYNTHESIS
    if (DEBUG) begin : g_dbg
        always @(negedge clk) begin
            if (run)
                for (int r = 0; r < NREGS; r++)
                    if (mem[r] != '0)
                        $display("f%0d = 0x%h (%0d)", r, mem[r], $signed(mem[r]));
        end
    end
`endif

endmodule

// File: tb/tb_fp_regfile_mp.sv
module tb_fp_regfile_mp;

    localparam int XLEN = 32, NREGS = 32, NRD = 3, NWR = 2, RAW = 6;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NRD*RAW-1:0]  rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*RAW-1:0]  wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [RAW-1:0]      iss_addr;
    logic                iss_stall;
    logic                flush;
    logic                init_done;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    always #5 clk = ~clk;

    fp_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .DEBUG(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr_pi(rd_addr), .rd_data_po(rd_data), .rd_busy_po(rd_busy),
        .wr_en_pi(wr_en), .wr_addr_pi(wr_addr), .wr_data_pi(wr_data),
        .iss_en_pi(iss_en), .iss_addr_pi(iss_addr), .iss_stall_po(iss_stall),
        .flush_pi(flush), .init_done_po(init_done)
    );

    function automatic logic [RAW-1:0] sp(input logic v, input int idx);
        return {v, 5'(idx)};
    endfunction

    task automatic idle();
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    // Drive point: just after the active edge; compare point: negedge.
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wr(input int p, input logic [RAW-1:0] a, input logic [31:0] d);
        wr_en[p] = 1'b1; wr_addr[p*RAW +: RAW] = a; wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic run_init();
        for (int c = 1; c <= NREGS; c++) begin
            step();
            exp_q.push_back((c == NREGS) ? 32'd1 : 32'd0);
            exp_q.push_back((c == NREGS) ? 32'd0 : 32'd1);
            smp();
            e = exp_q.pop_front(); n_cmp++;
            if (32'(init_done) !== e) begin n_fail++; $display("FAIL init_done c=%0d got=%0d exp=%0d", c, init_done, e); end
            e = exp_q.pop_front(); n_cmp++;
            if (32'(iss_stall) !== e) begin n_fail++; $display("FAIL init_stall c=%0d got=%0d exp=%0d", c, iss_stall, e); end
        end
    endtask

    task automatic chk_reset_state(input string tag);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        smp();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(init_done) !== e) begin n_fail++; $display("FAIL %s_done got=%0d exp=%0d", tag, init_done, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(iss_stall) !== e) begin n_fail++; $display("FAIL %s_stall got=%0d exp=%0d", tag, iss_stall, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(rd_busy) !== e) begin n_fail++; $display("FAIL %s_busy got=%0h exp=%0h", tag, rd_busy, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL %s_data got=%h exp=%h", tag, rd_data[31:0], e); end
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        rd_addr[0 +: RAW] = sp(1, 1);
        iss_addr = sp(1, 0);
        step(); step();
        chk_reset_state("rst");
        reset_n = 1'b1;   // released just after an edge: next edge is cycle 1
        run_init();
        for (int r = 0; r < NREGS; r++) begin
            rd_addr[0 +: RAW] = sp(1, r);
            exp_q.push_back(32'h0);
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL clear_f%0d got=%h exp=%h", r, rd_data[31:0], e); end
        end
    endtask

    task automatic test_write_bypass();
        step(); idle();
        wr(0, sp(1, 5), 32'h3F800000);
        rd_addr[1*RAW +: RAW] = sp(1, 5);
        rd_addr[2*RAW +: RAW] = sp(1, 6);
        exp_q.push_back(32'h3F800000); exp_q.push_back(32'h0);
        smp();
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[32 +: 32] !== e) begin n_fail++; $display("FAIL bypass_f5 got=%h exp=%h", rd_data[32 +: 32], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[64 +: 32] !== e) begin n_fail++; $display("FAIL bypass_f6 got=%h exp=%h", rd_data[64 +: 32], e); end
        for (int k = 0; k < 2; k++) begin
            step(); wr_en = '0;
            exp_q.push_back(32'h3F800000);
            smp();
            e = exp_q.pop_front(); n_cmp++;
            if (rd_data[32 +: 32] !== e) begin n_fail++; $display("FAIL stored_f5 got=%h exp=%h", rd_data[32 +: 32], e); end
        end
    endtask

    task automatic test_collision();
        step(); idle();
        wr(0, sp(1, 7), 32'h11111111);
        wr(1, sp(1, 7), 32'h22222222);
        rd_addr[0 +: RAW] = sp(1, 7);
        exp_q.push_back(32'h22222222);
        smp();
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL coll_bypass got=%h exp=%h", rd_data[31:0], e); end
        step(); wr_en = '0;
        exp_q.push_back(32'h22222222);
        smp();
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL coll_stored got=%h exp=%h", rd_data[31:0], e); end
    endtask

    task automatic test_scoreboard();
        step(); idle();
        iss_en = 1'b1; iss_addr = sp(1, 3); rd_addr[2*RAW +: RAW] = sp(1, 3);
        exp_q.push_back(0); exp_q.push_back(0);
        smp();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(iss_stall) !== e) begin n_fail++; $display("FAIL sb_first_stall got=%0d exp=%0d", iss_stall, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(rd_busy[2]) !== e) begin n_fail++; $display("FAIL sb_busy_N got=%0d exp=%0d", rd_busy[2], e); end
        step();   // cycle N+1, second issue to f3 held
        exp_q.push_back(1); exp_q.push_back(1);
        smp();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(rd_busy[2]) !== e) begin n_fail++; $display("FAIL sb_busy_N1 got=%0d exp=%0d", rd_busy[2], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(iss_stall) !== e) begin n_fail++; $display("FAIL sb_waw_stall got=%0d exp=%0d", iss_stall, e); end
        step(); iss_en = 1'b0;
        wr(1, sp(1, 3), 32'hCAFE0003);   // writeback in cycle M
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(32'hCAFE0003);
        smp();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(rd_busy[2]) !== e) begin n_fail++; $display("FAIL sb_wb_busy got=%0d exp=%0d", rd_busy[2], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(iss_stall) !== e) begin n_fail++; $display("FAIL sb_wb_stall got=%0d exp=%0d", iss_stall, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[64 +: 32] !== e) begin n_fail++; $display("FAIL sb_wb_data got=%h exp=%h", rd_data[64 +: 32], e); end
        step(); wr_en = '0;
        exp_q.push_back(0);
        smp();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(rd_busy[2]) !== e) begin n_fail++; $display("FAIL sb_cleared got=%0d exp=%0d", rd_busy[2], e); end
    endtask

    task automatic test_simultaneous();
        step(); idle();
        iss_en = 1'b1; iss_addr = sp(1, 9);
        wr(0, sp(1, 9), 32'h00000909);
        step(); idle();
        rd_addr[0 +: RAW] = sp(1, 9);
        exp_q.push_back(1); exp_q.push_back(32'h00000909);
        smp();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(rd_busy[0]) !== e) begin n_fail++; $display("FAIL sim_issue_wins got=%0d exp=%0d", rd_busy[0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL sim_f9_data got=%h exp=%h", rd_data[31:0], e); end
        step();
        flush = 1'b1; iss_en = 1'b1; iss_addr = sp(1, 4);
        step(); idle();
        rd_addr[0 +: RAW] = sp(1, 9); rd_addr[1*RAW +: RAW] = sp(1, 4); iss_addr = sp(1, 4);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        smp();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(rd_busy[0]) !== e) begin n_fail++; $display("FAIL flush_f9 got=%0d exp=%0d", rd_busy[0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(rd_busy[1]) !== e) begin n_fail++; $display("FAIL flush_f4_busy got=%0d exp=%0d", rd_busy[1], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(iss_stall) !== e) begin n_fail++; $display("FAIL flush_f4_stall got=%0d exp=%0d", iss_stall, e); end
    endtask

    task automatic test_invalid_and_reset();
        step(); idle();
        wr(0, sp(0, 5), 32'hDEADBEEF);
        iss_en = 1'b1; iss_addr = sp(1, 10);
        rd_addr[0 +: RAW] = sp(0, 5);
        exp_q.push_back(0);
        smp();
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL inv_read got=%h exp=%h", rd_data[31:0], e); end
        step(); idle();
        rd_addr[0 +: RAW] = sp(1, 5); rd_addr[1*RAW +: RAW] = sp(0, 10); rd_addr[2*RAW +: RAW] = sp(1, 10);
        iss_addr = sp(0, 10);
        exp_q.push_back(32'h3F800000); exp_q.push_back(32'b100); exp_q.push_back(0);
        smp();
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL inv_write_dropped got=%h exp=%h", rd_data[31:0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(rd_busy) !== e) begin n_fail++; $display("FAIL inv_busy got=%b exp=%b", rd_busy, e[2:0]); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(iss_stall) !== e) begin n_fail++; $display("FAIL inv_issue_stall got=%0d exp=%0d", iss_stall, e); end
        for (int c = 0; c < 10; c++) step();
        reset_n = 1'b0;
        rd_addr[0 +: RAW] = sp(1, 5);
        iss_addr = sp(1, 0);
        step();
        chk_reset_state("midrst");
        reset_n = 1'b1;
        run_init();
        rd_addr[0 +: RAW] = sp(1, 5);
        exp_q.push_back(0); exp_q.push_back(0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL midrst_recleared got=%h exp=%h", rd_data[31:0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(rd_busy[2]) !== e) begin n_fail++; $display("FAIL midrst_pending got=%0d exp=%0d", rd_busy[2], e); end
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        test_reset();
        test_write_bypass();
        test_collision();
        test_scoreboard();
        test_simultaneous();
        test_invalid_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_regfile_mp.md
# fp_regfile_mp

Parametrised successor to the single-write FP register file. Multi-port FP register file with configurable data width, register count, and read/write port counts. Adds a per-register pending scoreboard for issue-stage hazard detection and a sequential clear engine that zeroes storage one entry per cycle after reset, so the array maps to LUTRAM instead of a flop bank. It sits between the FP issue stage (source reads, destination reservation) and the FP writeback stage; up to `NWR` writebacks arrive per cycle.

## Interface
- `XLEN`, 32: data width; legal values are 32 or 64.
- `NREGS`, 32: number of registers; power of two, from 2 to 32.
- `NRD`, 3: number of read ports; 3 are needed for fused multiply-add.
- `NWR`, 2: number of write ports.
- `DEBUG`, 0: when 1, enables a simulation-only register dump on negedge.
- Derived: `RAW = $clog2(NREGS)+1`. Specifier MSB = FP-valid; low bits = index.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `rd_addr_pi`  in  NRD*RAW  read specifiers, packed; port i uses slice i.
- `rd_data_po`  out  NRD*XLEN  read data.
- `rd_busy_po`  out  NRD  source i is pending and not bypassed this cycle.
- `wr_en_pi`  in  NWR  per-port write enable.
- `wr_addr_pi`  in  NWR*RAW  write specifiers.
- `wr_data_pi`  in  NWR*XLEN  write data.
- `iss_en_pi`  in  1  reserve a destination register.
- `iss_addr_pi`  in  RAW  destination specifier to reserve.
- `iss_stall_po`  out  1  reservation refused (init in progress, or WAW hazard).
- `flush_pi`  in  1  clear all pending bits.
- `init_done_po`  out  1  clear engine has finished.

## Operation
- **Specifier valid bit.** If the specifier MSB is 0:
  - the read returns 0 with busy 0;
  - the write is dropped;
  - the issue is ignored, with no stall.
- **State machine.** Two states, `RF_INIT` and `RF_RUN`.
  - `reset_n` low sends the block to `RF_INIT`, sets clear counter = 0, and clears all pending bits.
  - In `RF_INIT`, each `reset_n`-high cycle writes 0 to `mem[counter]` and increments the counter.
  - When the counter reaches `NREGS-1`, the next state is `RF_RUN`.
- **During `RF_INIT`:**
  - `rd_data_po` = 0 and `rd_busy_po` = 0;
  - `wr_en_pi` is ignored;
  - `iss_stall_po` = 1;
  - `init_done_po` = 0.
- **Writes (`RF_RUN`).** Every enabled port with a valid specifier writes `mem[idx]` at the clock edge. If several ports hit the same index, the highest port number wins.
- **Reads.** Reads are combinational.
  - If any enabled write port targets the same valid index in the same cycle, the read returns that write data (highest matching port wins).
  - Otherwise the read returns `mem[idx]`.
- **Scoreboard.** `pending[NREGS]`.
  - An issue with valid `iss_addr_pi` and `iss_stall_po` = 0 sets `pending[idx]`.
  - Any valid write clears `pending[idx]`.
  - Issue and write to the same index in the same cycle: the issue wins, so pending stays 1 (the new producer owns the register).
  - `flush_pi` clears all pending bits and drops a same-cycle issue. Same-cycle writes still update `mem`.
- **Busy output.** `rd_busy_po[i]` = valid & `pending[idx]` & no same-cycle write to idx.
- **Stall output.** `iss_stall_po` = INIT | (valid & `pending[idx]` & no same-cycle write to idx).
- **Debug.** `DEBUG` prints nonzero registers in hex and signed decimal at negedge; it is excluded from synthesis.

## Timing
- Read latency is 0 (combinational). Write-to-read is 0 cycles via bypass, and 1 cycle via storage.
- Pending set/clear takes effect at the next clock edge. An issue in cycle N makes `rd_busy_po` visible in cycle N+1.
- `init_done_po` rises exactly `NREGS` cycles after the first `reset_n`-high cycle, i.e. 32 cycles at default.
- Reset values:
  - `init_done_po` = 0;
  - `iss_stall_po` = 1;
  - `rd_busy_po` = 0;
  - `rd_data_po` = 0;
  - pending all 0.
- Reset mid-operation, in either state, restarts `RF_INIT` from counter 0. Storage contents are undefined until re-cleared.
- No output depends combinationally on `reset_n`.

## Structure
- Package `fp_rf_pkg` holds:
  - state enum `rf_state_t` {`RF_INIT`, `RF_RUN`};
  - function `fp_spec_valid`;
  - function `fp_spec_idx`.
- Sub-module `fp_scoreboard` contains the pending vector, set/clear/flush priority, and the busy/stall generation. It is parametrised by `NREGS`, `NRD`, `NWR` and `RAW`.
- Storage, the bypass mux and the clear FSM live in the top module.

## Test plan
- **Reset/init.** Hold `reset_n`=0 for 2 cycles, then release. Expect `init_done_po`=0 and `iss_stall_po`=1 for 32 cycles, then 1 and 0. All registers read 0.
- **Write/bypass.** Write port 0 `f5`←`0x3F800000` while read port 1 reads `f5` in the same cycle. Expect `0x3F800000` in that cycle and on every later read.
- **Write collision.** Ports 0 and 1 both write `f7` (`0x11111111`, `0x22222222`). Expect `f7`=`0x22222222`, and the bypass read returns `0x22222222`.
- **Scoreboard.**
  - Issue `f3` in cycle N: `rd_busy_po`=1 on a read of `f3` in N+1.
  - A second issue to `f3` stalls.
  - Writeback of `f3` in cycle M: busy=0 and stall=0 in cycle M.
- **Simultaneous events.**
  - Issue and writeback to `f9` in the same cycle: pending stays 1.
  - `flush_pi` together with an issue to `f4`: all pending 0 and `f4` not reserved.
- **Invalid specifier and mid-run reset.**
  - A write with MSB=0 leaves storage unchanged, and a read with MSB=0 returns 0.
  - Asserting `reset_n`=0 at cycle 10 of `RF_RUN` re-enters `RF_INIT` and clears pending.
